// File: rtl/a_lockout_timer_if.sv
// Error-processor handshake (gen_stop / error_counter / rst_out) plus the lock
// status driven towards the display and keypad-enable logic.
interface a_lockout_timer_if #(
   parameter int SEC_W = 8
);
   logic             gen_stop;
   logic [2:0]       error_counter;
   logic             rst_out;
   logic             lock_active;
   logic [SEC_W-1:0] remaining_sec;
   logic             perm_lock;

   modport master (
      output gen_stop, error_counter,
      input  rst_out, lock_active, remaining_sec, perm_lock
   );

   modport slave (
      input  gen_stop, error_counter,
      output rst_out, lock_active, remaining_sec, perm_lock
   );
endinterface

// File: rtl/a_lockout_timer.sv
// Penalty countdown after a lock request; the penalty doubles per failed attempt.
// Optional terminal lockout on the seventh error: define LOCKOUT_PERMANENT_EN.
module a_lockout_timer #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BASE_SEC = 5,
   parameter int MAX_SEC  = 255,
   parameter int SEC_W    = 8
) (
   input  logic             clk,
   input  logic             rst_in,
   a_lockout_timer_if.slave bus
);
   localparam int               PRE_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ - 1);
   localparam int               PEN_W    = SEC_W + 7;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COUNT,
      RELEASE,
`ifdef LOCKOUT_PERMANENT_EN
      PERM,
`endif
      WAIT_CLR
   } state_e;

   state_e           state;
   logic [PRE_W-1:0] prescaler;
   logic [SEC_W-1:0] rem_q;
   logic             rst_out_q;
   logic             lock_q;
   logic             s1, s2, s3;
   logic             rise;
   logic             tick;
   logic [2:0]       n_sel;
   logic [PEN_W-1:0] pen_wide;
   logic [SEC_W-1:0] penalty;

   // gen_stop is asynchronous to clk: two flops for metastability, a third for edge detect.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= bus.gen_stop;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;
   assign tick = (prescaler == PRE_LAST);

   // The shift is evaluated wide so large attempt counts clamp instead of wrapping.
   always_comb begin
      n_sel    = (bus.error_counter == 3'd0) ? 3'd1 : bus.error_counter;
      pen_wide = PEN_W'(BASE_SEC) << (n_sel - 3'd1);
      penalty  = (pen_wide > PEN_W'(MAX_SEC)) ? SEC_W'(MAX_SEC) : pen_wide[SEC_W-1:0];
   end

`ifdef LOCKOUT_PERMANENT_EN
   logic perm_q;
`endif

   // NOTE: non-blocking assignments throughout; the permanent-lock override in LOAD
   // relies on the later assignment to the same register winning.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         state     <= IDLE;
         prescaler <= '0;
         rem_q     <= '0;
         rst_out_q <= 1'b0;
         lock_q    <= 1'b0;
`ifdef LOCKOUT_PERMANENT_EN
         perm_q    <= 1'b0;
`endif
      end else begin
         rst_out_q <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  state  <= LOAD;
                  lock_q <= 1'b1;
               end
            end
            LOAD: begin
               rem_q     <= penalty;
               prescaler <= '0;
               state     <= COUNT;
`ifdef LOCKOUT_PERMANENT_EN
               if (bus.error_counter == 3'd7) begin
                  rem_q  <= '0;
                  perm_q <= 1'b1;
                  state  <= PERM;
               end
`endif
            end
            COUNT: begin
               if (tick) begin
                  prescaler <= '0;
                  if (rem_q > SEC_W'(1)) begin
                     rem_q <= rem_q - 1'b1;
                  end else begin
                     rem_q     <= '0;
                     rst_out_q <= 1'b1;
                     state     <= RELEASE;
                  end
               end else begin
                  prescaler <= prescaler + 1'b1;
               end
            end
            RELEASE: begin
               lock_q <= 1'b0;
               state  <= WAIT_CLR;
            end
            WAIT_CLR: begin
               // Wait for the error processor to drop its request; rises here are ignored.
               if (!s2) state <= IDLE;
            end
`ifdef LOCKOUT_PERMANENT_EN
            PERM: begin
               state <= PERM;
            end
`endif
            default: begin
               state  <= IDLE;
               lock_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rst_out       = rst_out_q;
   assign bus.lock_active   = lock_q;
   assign bus.remaining_sec = rem_q;
`ifdef LOCKOUT_PERMANENT_EN
   assign bus.perm_lock     = perm_q;
`else
   assign bus.perm_lock     = 1'b0;
`endif
endmodule

// File: tb/tb_a_lockout_timer.sv
// Self-checking bench for a_lockout_timer: timeline model checked every cycle plus
// literal expectations from the test plan (CLK_FREQ=10, BASE_SEC=2, MAX_SEC=20).
module tb_a_lockout_timer;
   localparam int CLK_FREQ = 10;
   localparam int BASE_SEC = 2;
   localparam int MAX_SEC  = 20;
   localparam int SEC_W    = 8;

   logic clk = 1'b0;
   logic rst_in = 1'b1;
   always #5 clk = ~clk;

   a_lockout_timer_if #(.SEC_W(SEC_W)) bus ();

   a_lockout_timer #(
      .CLK_FREQ(CLK_FREQ),
      .BASE_SEC(BASE_SEC),
      .MAX_SEC (MAX_SEC),
      .SEC_W   (SEC_W)
   ) dut (
      .clk   (clk),
      .rst_in(rst_in),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Penalty from the attempt count: base doubled per extra attempt, capped.
   function automatic int pen_of(input int e);
      int n;
      int p;
      n = (e == 0) ? 1 : e;
      p = BASE_SEC * (1 << (n - 1));
      return (p > MAX_SEC) ? MAX_SEC : p;
   endfunction

   // Timeline model: remembers the edge at which a lock began and derives every
   // output from the elapsed cycle count.
   int cyc = 0;
   bit q0, q1, q2;          // gen_stop as sampled 1, 2 and 3 edges ago
   bit m_valid  = 1'b0;
   bit m_locked = 1'b0;
   bit m_perm   = 1'b0;
   int load_t   = 0;
   int pen      = 0;

   always @(posedge clk) begin
      cyc++;
      if (rst_in) begin
         m_valid  = 1'b1;
         m_locked = 1'b0;
         m_perm   = 1'b0;
         q0 = 1'b0; q1 = 1'b0; q2 = 1'b0;
      end else if (m_valid) begin
         if (!m_locked) begin
            if (q1 && !q2) begin
               m_locked = 1'b1;
               load_t   = cyc;
            end
         end else if (!m_perm) begin
            if (cyc - load_t == 1) begin
               pen = pen_of(int'(bus.error_counter));
`ifdef LOCKOUT_PERMANENT_EN
               if (bus.error_counter == 3'd7) m_perm = 1'b1;
`endif
            end else if (cyc - load_t >= pen * CLK_FREQ + 3 && !q1) begin
               m_locked = 1'b0;
            end
         end
         q2 = q1;
         q1 = q0;
         q0 = bus.gen_stop;
      end
   end

   int dd, e_lock, e_rem, e_rst, e_perm;
   always @(negedge clk) begin
      if (m_valid) begin
         e_lock = 0; e_rem = 0; e_rst = 0; e_perm = 0;
         if (m_perm) begin
            e_lock = 1;
            e_perm = 1;
         end else if (m_locked) begin
            dd = cyc - load_t;
            if (dd == 0) begin
               e_lock = 1;
            end else if (dd <= pen * CLK_FREQ) begin
               e_lock = 1;
               e_rem  = pen - (dd - 1) / CLK_FREQ;
            end else if (dd == pen * CLK_FREQ + 1) begin
               e_lock = 1;
               e_rst  = 1;
            end
         end
         check("model_lock_active",   bus.lock_active,   e_lock);
         check("model_remaining_sec", bus.remaining_sec, e_rem);
         check("model_rst_out",       bus.rst_out,       e_rst);
         check("model_perm_lock",     bus.perm_lock,     e_perm);
      end
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Raise gen_stop, check the loaded penalty at COUNT entry and the release latency.
   task automatic run_lock(input logic [2:0] e, input int exp_pen);
      int cnt;
      bus.error_counter = e;
      bus.gen_stop      = 1'b1;
      edges(1);
      edges(3);
      check("rem_at_count_entry", bus.remaining_sec, exp_pen);
      cnt = 0;
      while (bus.rst_out !== 1'b1 && cnt <= exp_pen * CLK_FREQ + 20) begin
         edges(1);
         cnt++;
      end
      check("release_latency", cnt, exp_pen * CLK_FREQ);
      bus.gen_stop = 1'b0;
      edges(6);
      check("lock_after_clear", bus.lock_active, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
      $fatal(1, "watchdog expired");
   end

   int pulses;
   initial begin
      bus.gen_stop      = 1'b0;
      bus.error_counter = 3'd0;
      rst_in            = 1'b1;
      edges(3);
      rst_in = 1'b0;
      check("reset_lock_active", bus.lock_active, 0);
      check("reset_remaining",   bus.remaining_sec, 0);
      check("reset_rst_out",     bus.rst_out, 0);
      check("reset_perm_lock",   bus.perm_lock, 0);

      // err=1: rise sampled at edge k
      bus.error_counter = 3'd1;
      bus.gen_stop      = 1'b1;
      edges(1);                                         // k
      edges(1);  check("t1_lock_k1",  bus.lock_active, 0);
      edges(1);  check("t1_lock_k2",  bus.lock_active, 1);
      edges(1);  check("t1_rem_k3",   bus.remaining_sec, 2);
      edges(10); check("t1_rem_k13",  bus.remaining_sec, 1);
      edges(9);  check("t1_rst_k22",  bus.rst_out, 0);
      edges(1);  check("t1_rst_k23",  bus.rst_out, 1);
                 check("t1_rem_k23",  bus.remaining_sec, 0);
      edges(1);  check("t1_rst_k24",  bus.rst_out, 0);
                 check("t1_lock_k24", bus.lock_active, 0);
      edges(1);
      bus.gen_stop = 1'b0;
      edges(5);  check("t1_lock_idle", bus.lock_active, 0);

      run_lock(3'd3, 8);
      run_lock(3'd5, 20);
      run_lock(3'd0, 2);

      // Hold gen_stop long after release: no second pulse, then a fresh rise relocks.
      bus.error_counter = 3'd1;
      bus.gen_stop      = 1'b1;
      edges(1);
      edges(23); check("hold_rst_k23", bus.rst_out, 1);
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         edges(1);
         pulses += int'(bus.rst_out);
      end
      check("hold_no_second_pulse", pulses, 0);
      check("hold_lock_low",        bus.lock_active, 0);
      bus.gen_stop = 1'b0;
      edges(4);
      bus.error_counter = 3'd3;
      bus.gen_stop      = 1'b1;
      edges(1);
      edges(2);  check("relock_lock", bus.lock_active, 1);

      // Reset mid-count with 5 seconds left aborts silently.
      edges(1);  check("relock_rem_entry", bus.remaining_sec, 8);
      edges(30); check("abort_rem_5",      bus.remaining_sec, 5);
      rst_in       = 1'b1;
      bus.gen_stop = 1'b0;
      edges(1);
      rst_in = 1'b0;
      check("abort_lock",   bus.lock_active, 0);
      check("abort_rem",    bus.remaining_sec, 0);
      check("abort_rst",    bus.rst_out, 0);
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
         edges(1);
         pulses += int'(bus.rst_out);
      end
      check("abort_no_pulse", pulses, 0);

`ifdef LOCKOUT_PERMANENT_EN
      bus.error_counter = 3'd7;
      bus.gen_stop      = 1'b1;
      edges(1);
      edges(3);
      check("perm_flag", bus.perm_lock, 1);
      check("perm_lock", bus.lock_active, 1);
      check("perm_rem",  bus.remaining_sec, 0);
      pulses = 0;
      for (int i = 0; i < 1000; i++) begin
         edges(1);
         pulses += int'(bus.rst_out);
      end
      check("perm_no_pulse",  pulses, 0);
      check("perm_held",      bus.perm_lock, 1);
      rst_in       = 1'b1;
      bus.gen_stop = 1'b0;
      edges(1);
      rst_in = 1'b0;
      check("perm_cleared",   bus.perm_lock, 0);
      check("perm_lock_free", bus.lock_active, 0);
`else
      run_lock(3'd7, 20);
      check("no_perm_flag", bus.perm_lock, 0);
`endif

      edges(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/a_lockout_timer.md
Name: a_lockout_timer

Overview:
- Counterpart to the error processor. Consumes its lock request (gen_stop) and attempt count (error_counter), and runs a penalty countdown in seconds.
- The penalty doubles with each failed attempt.
- On expiry it issues the single-cycle release pulse (rst_out) that clears gen_stop.
- Sits between the password-check path and the display/keypad-enable logic.

Parameters:
- CLK_FREQ, 50_000_000, clock cycles per second tick.
- BASE_SEC, 5, penalty in seconds for the first error.
- MAX_SEC, 255, penalty ceiling in seconds.
- SEC_W, 8, width of the remaining-seconds counter; MAX_SEC must fit in it.

Ports:
- clk  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- gen_stop  input  1  lock request from the error processor; level, asynchronous to clk.
- error_counter  input  3  failed-attempt count, 0..7, saturating at 7.
- rst_out  output  1  release pulse to the error processor; 1 cycle wide.
- lock_active  output  1  high while the keypad must be ignored.
- remaining_sec  output  SEC_W  seconds left, for the display.
- perm_lock  output  1  permanent lockout flag (see Optional Feature).

Behaviour:
- Reset: rst_in is sampled on the clk rising edge and takes priority over everything. On reset:
  - state=IDLE, rst_out=0, lock_active=0, remaining_sec=0, perm_lock=0.
  - prescaler=0, synchroniser flops=0, edge flop=0.
  - Reset during any state aborts the countdown with no rst_out pulse.
- Input sync: gen_stop passes through a 2-flop synchroniser (s1, s2). Edge flop s3<=s2. rise = s2 & ~s3.
- error_counter is quasi-static when rise fires and is sampled directly.
- States:
  - IDLE: on rise go to LOAD. Otherwise stay.
  - LOAD (1 cycle):
    - n = max(error_counter, 1).
    - penalty = min(BASE_SEC << (n-1), MAX_SEC), computed at SEC_W+7 bits before clamping.
    - Load remaining_sec=penalty, prescaler=0, go to COUNT.
  - COUNT:
    - Prescaler counts 0..CLK_FREQ-1; tick when it equals CLK_FREQ-1, then it wraps to 0.
    - On tick with remaining_sec>1: decrement.
    - On tick with remaining_sec==1: remaining_sec=0, go to RELEASE.
  - RELEASE (1 cycle): rst_out=1, then go to WAIT_CLR.
  - WAIT_CLR: stay until s2==0, then go to IDLE. Any rise seen here is ignored.
- lock_active=1 in LOAD, COUNT and RELEASE; 0 otherwise. Registered, asserted the same cycle the state is entered.
- Latency:
  - gen_stop high at edge k → LOAD at k+2, COUNT at k+3.
  - rst_out high exactly penalty*CLK_FREQ cycles after COUNT entry.
- Errors arriving during COUNT leave gen_stop high, so no new edge fires and the count is not restarted.
- gen_stop dropping during COUNT (another source cleared it) does not shorten the countdown.
- All outputs are registered; no combinational path from input to output.

Optional Feature:
- Macro: LOCKOUT_PERMANENT_EN.
- Defined: in LOAD, if error_counter==7:
  - Set perm_lock=1, lock_active=1, remaining_sec=0, and enter the terminal state PERM.
  - No rst_out is ever generated.
  - Only rst_in exits PERM.
- Undefined: PERM and the perm_lock logic are absent; perm_lock is tied to 0. Count 7 gets the normal clamped penalty.

Test Plan (CLK_FREQ=10, BASE_SEC=2, MAX_SEC=20, SEC_W=8):
- err=1, gen_stop rises at cycle 0:
  - lock_active=1 from cycle 2; remaining_sec=2 at COUNT entry (cycle 3).
  - remaining_sec=1 at cycle 13; single rst_out pulse at cycle 23.
  - Drop gen_stop at cycle 25 → IDLE, lock_active=0.
- err=3 → penalty 8; err=5 → 32, clamped to 20. Check remaining_sec at COUNT entry and rst_out exactly 80 / 200 cycles after COUNT entry.
- err=0 with a gen_stop rise → treated as 1, penalty 2.
- Hold gen_stop high 50 cycles past rst_out → stays in WAIT_CLR, no second pulse. Fall then rise again → new LOAD.
- rst_in pulsed mid-COUNT with remaining_sec=5 → next cycle all outputs 0, no rst_out.
- LOCKOUT_PERMANENT_EN defined, err=7 → perm_lock=1, lock_active=1, no rst_out for 1000 cycles; cleared only by rst_in. Undefined → penalty 20 and normal release.
